// File: rtl/drum_pkg.sv
// +----------------------------------------------------------------------------+
// | drum_pkg: shared grid geometry, widths and loader state encoding.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

package drum_pkg;

  localparam int N_ROWS     = 30;
  localparam int N_COLS     = 30;
  localparam int NODE_W     = 18;
  localparam int LUT_ADDR_W = 19;
  localparam int IDX_W      = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } loader_state_e;

endpackage

`default_nettype wire

// File: rtl/drum_grid_counter.sv
// +----------------------------------------------------------------------------+
// | drum_grid_counter: column-major row/col counter with wrap and last flag.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module drum_grid_counter #(
  parameter int N_ROWS = drum_pkg::N_ROWS,
  parameter int N_COLS = drum_pkg::N_COLS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       advance,
  output logic [drum_pkg::IDX_W-1:0] row,
  output logic [drum_pkg::IDX_W-1:0] col,
  output logic                       last
);
  import drum_pkg::*;

  localparam logic [IDX_W-1:0] ROW_MAX = IDX_W'(N_ROWS - 1);
  localparam logic [IDX_W-1:0] COL_MAX = IDX_W'(N_COLS - 1);

  logic [IDX_W-1:0] row_d, row_q;
  logic [IDX_W-1:0] col_d, col_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      // Rows are the inner loop; the column steps only when a row pass wraps.
      if (row_q == ROW_MAX) begin
        row_d = '0;
        col_d = (col_q == COL_MAX) ? '0 : col_q + IDX_W'(1);
      end else begin
        row_d = row_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = (row_q == ROW_MAX) && (col_q == COL_MAX);

endmodule

`default_nettype wire

// File: rtl/drum_init_loader.sv
// +----------------------------------------------------------------------------+
// | drum_init_loader: sweeps the init LUT and streams every node to memories.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module drum_init_loader #(
  parameter int N_ROWS = drum_pkg::N_ROWS,
  parameter int N_COLS = drum_pkg::N_COLS,
  parameter int NODE_W = drum_pkg::NODE_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  output logic [drum_pkg::LUT_ADDR_W-1:0] lut_addr,
  input  logic [NODE_W-1:0]               lut_data,
  output logic                            wr_valid,
  input  logic                            wr_ready,
  output logic [drum_pkg::IDX_W-1:0]      wr_col,
  output logic [drum_pkg::IDX_W-1:0]      wr_row,
  output logic [NODE_W-1:0]               wr_data,
  output logic                            busy,
  output logic                            done
);
  import drum_pkg::*;

  loader_state_e     state_d, state_q;
  logic              pending_d, pending_q;
  logic              wr_valid_d, wr_valid_q;
  logic [NODE_W-1:0] wr_data_d, wr_data_q;
  logic [IDX_W-1:0]  wr_row_d, wr_row_q;
  logic [IDX_W-1:0]  wr_col_d, wr_col_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;

  logic              cnt_clear;
  logic              cnt_advance;
  logic              cnt_last;
  logic [IDX_W-1:0]  cnt_row;
  logic [IDX_W-1:0]  cnt_col;
  logic              accept;
  logic              load;

  drum_grid_counter #(
    .N_ROWS (N_ROWS),
    .N_COLS (N_COLS)
  ) u_grid_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .row     (cnt_row),
    .col     (cnt_col),
    .last    (cnt_last)
  );

  // pending_q marks that the counters point at a node not yet captured.
  assign accept = wr_valid_q && wr_ready;
  assign load   = (state_q == ST_LOAD) && pending_q && (!wr_valid_q || wr_ready);

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    wr_valid_d  = wr_valid_q;
    wr_data_d   = wr_data_q;
    wr_row_d    = wr_row_q;
    wr_col_d    = wr_col_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          pending_d = 1'b1;
          busy_d    = 1'b1;
          cnt_clear = 1'b1;
        end
      end
      ST_LOAD: begin
        if (load) begin
          wr_valid_d = 1'b1;
          wr_data_d  = lut_data;
          wr_row_d   = cnt_row;
          wr_col_d   = cnt_col;
          if (cnt_last) begin
            pending_d = 1'b0;
          end else begin
            cnt_advance = 1'b1;
          end
        end else if (accept) begin
          wr_valid_d = 1'b0;
        end
        if (accept && !pending_q) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pending_q  <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_data_q  <= '0;
      wr_row_q   <= '0;
      wr_col_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      wr_valid_q <= wr_valid_d;
      wr_data_q  <= wr_data_d;
      wr_row_q   <= wr_row_d;
      wr_col_q   <= wr_col_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign lut_addr = ((state_q == ST_LOAD) && pending_q)
                  ? LUT_ADDR_W'(cnt_row) * LUT_ADDR_W'(N_COLS) + LUT_ADDR_W'(cnt_col)
                  : '0;

  assign wr_valid = wr_valid_q;
  assign wr_data  = wr_data_q;
  assign wr_row   = wr_row_q;
  assign wr_col   = wr_col_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_drum_init_loader.sv
// +----------------------------------------------------------------------------+
// | tb_drum_init_loader: randomized sweeps checked against a beat-order model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_drum_init_loader;

  localparam int NR = 30;
  localparam int NC = 30;
  localparam int NW = 18;
  localparam int NB = NR * NC;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          wr_ready;
  logic          wr_valid;
  logic          busy;
  logic          done;
  logic [18:0]   lut_addr;
  logic [NW-1:0] lut_data;
  logic [NW-1:0] wr_data;
  logic [4:0]    wr_col;
  logic [4:0]    wr_row;

  logic [NW-1:0] lut_mem [NB];
  logic [18:0]   addr_log [4096];
  logic [NW-1:0] beat_data [NB];

  int vectors     = 0;
  int miscompares = 0;

  int s_nbeats, s_ndone, s_done_cycle, s_first_valid, s_final_cycle;
  int s_order_err, s_data_err, s_stall_err, s_busy_err, s_done_err, s_post_err, s_timeout;

  always #5 clk = ~clk;

  assign lut_data = (lut_addr < 19'(NB)) ? lut_mem[lut_addr] : '0;

  drum_init_loader #(
    .N_ROWS (NR),
    .N_COLS (NC),
    .NODE_W (NW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .lut_addr (lut_addr),
    .lut_data (lut_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_col   (wr_col),
    .wr_row   (wr_row),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done)
  );

  task automatic fill_lut();
    logic [NW-1:0] v;
    for (int i = 0; i < NB; i++) begin
      v = NW'($urandom);
      if (v == 18'h10000 || v == 18'h01249) v = v ^ 18'h00001;
      lut_mem[i] = v;
    end
    lut_mem[0]   = 18'h00000;
    lut_mem[434] = 18'h10000;
    lut_mem[31]  = 18'h01249;
  endtask

  // mode 0: ready always high, 1: random ready, 2: hold final beat 5 cycles.
  task automatic run_sweep(input int mode, input int restart_at, input int reset_at);
    int            c, stall_cnt, rst_cycle, exp_row, exp_col;
    bit            restart_fired, prev_stall, busy_exp;
    logic [NW-1:0] pd;
    logic [4:0]    pr, pc;
    s_nbeats = 0; s_ndone = 0; s_done_cycle = -1; s_first_valid = -1; s_final_cycle = -1;
    s_order_err = 0; s_data_err = 0; s_stall_err = 0; s_busy_err = 0; s_done_err = 0;
    s_post_err = 0; s_timeout = 0;
    stall_cnt = 0; rst_cycle = -1; restart_fired = 0; prev_stall = 0;
    pd = '0; pr = '0; pc = '0;
    @(posedge clk); #1;
    start = 1'b1; wr_ready = 1'b1; c = 0;
    forever begin
      @(negedge clk);
      if (c < 4096) addr_log[c] = lut_addr;
      if (rst_cycle >= 0 && c > rst_cycle) begin
        if (wr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            wr_data !== '0 || wr_row !== '0 || wr_col !== '0) s_post_err++;
        if (c >= rst_cycle + 10) break;
      end else begin
        if (prev_stall && (wr_valid !== 1'b1 || wr_data !== pd || wr_row !== pr || wr_col !== pc))
          s_stall_err++;
        if (wr_valid === 1'b1) begin
          if (s_first_valid < 0) s_first_valid = c;
          if (s_nbeats >= NB) begin
            s_order_err++;
          end else begin
            exp_row = s_nbeats % NR;
            exp_col = s_nbeats / NR;
            if (wr_row !== 5'(exp_row) || wr_col !== 5'(exp_col)) s_order_err++;
            if (wr_data !== lut_mem[exp_row * NC + exp_col]) s_data_err++;
            beat_data[s_nbeats] = wr_data;
          end
        end
        busy_exp = (c >= 1) && (s_final_cycle < 0 || c <= s_final_cycle);
        if (busy !== busy_exp) s_busy_err++;
        if (done === 1'b1) begin
          s_ndone++;
          s_done_cycle = c;
          if (s_final_cycle < 0 || c != s_final_cycle + 1) s_done_err++;
        end else if (s_final_cycle >= 0 && c == s_final_cycle + 1) begin
          s_done_err++;
        end
        prev_stall = (wr_valid === 1'b1) && (wr_ready === 1'b0);
        pd = wr_data; pr = wr_row; pc = wr_col;
        if (wr_valid === 1'b1 && wr_ready === 1'b1) begin
          s_nbeats++;
          if (s_nbeats == NB) s_final_cycle = c;
        end
        if (s_final_cycle >= 0 && c >= s_final_cycle + 3) break;
      end
      if (c >= 20000) begin
        s_timeout = 1;
        break;
      end
      @(posedge clk); #1;
      c++;
      start = 1'b0;
      reset = 1'b0;
      if (restart_at >= 0 && !restart_fired && s_nbeats >= restart_at) begin
        start = 1'b1;
        restart_fired = 1;
      end
      if (reset_at >= 0 && rst_cycle < 0 && s_nbeats >= reset_at) begin
        reset = 1'b1;
        rst_cycle = c;
      end
      case (mode)
        1: wr_ready = 1'($urandom_range(0, 1));
        2: begin
          if (wr_valid === 1'b1 && wr_row == 5'(NR - 1) && wr_col == 5'(NC - 1) && stall_cnt < 5) begin
            wr_ready = 1'b0;
            stall_cnt++;
          end else begin
            wr_ready = 1'b1;
          end
        end
        default: wr_ready = 1'b1;
      endcase
      if (reset) wr_ready = 1'b0;
    end
    start = 1'b0; reset = 1'b0; wr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({wr_valid, busy, done, wr_data, wr_row, wr_col, lut_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b b=%b d=%b data=%h row=%0d col=%0d addr=%0d required all zero",
               wr_valid, busy, done, wr_data, wr_row, wr_col, lut_addr);
    end
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || wr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_wins_over_start: got busy=%b valid=%b required 0 0", busy, wr_valid);
    end
  endtask

  task automatic test_full_sweep();
    run_sweep(0, -1, -1);
    vectors++; if (s_timeout !== 0) begin miscompares++; $display("FAIL full_timeout: got %0d required 0", s_timeout); end
    vectors++; if (s_first_valid !== 2) begin miscompares++; $display("FAIL full_first_valid_cycle: got %0d required 2", s_first_valid); end
    vectors++; if (s_nbeats !== NB) begin miscompares++; $display("FAIL full_beats: got %0d required %0d", s_nbeats, NB); end
    vectors++; if (s_ndone !== 1) begin miscompares++; $display("FAIL full_done_count: got %0d required 1", s_ndone); end
    vectors++; if (s_done_cycle !== 902) begin miscompares++; $display("FAIL full_done_cycle: got %0d required 902", s_done_cycle); end
    vectors++; if (s_order_err !== 0) begin miscompares++; $display("FAIL full_order: got %0d errors required 0", s_order_err); end
    vectors++; if (s_data_err !== 0) begin miscompares++; $display("FAIL full_data: got %0d errors required 0", s_data_err); end
    vectors++; if (s_busy_err !== 0) begin miscompares++; $display("FAIL full_busy: got %0d errors required 0", s_busy_err); end
    vectors++; if (addr_log[1] !== 19'd0) begin miscompares++; $display("FAIL addr_cycle1: got %0d required 0", addr_log[1]); end
    vectors++; if (addr_log[2] !== 19'd30) begin miscompares++; $display("FAIL addr_cycle2: got %0d required 30", addr_log[2]); end
    vectors++; if (addr_log[435] !== 19'd434) begin miscompares++; $display("FAIL addr_centre: got %0d required 434", addr_log[435]); end
    vectors++; if (addr_log[902] !== 19'd0) begin miscompares++; $display("FAIL addr_after_load: got %0d required 0", addr_log[902]); end
    vectors++; if (beat_data[0] !== 18'h00000) begin miscompares++; $display("FAIL data_origin: got %h required 00000", beat_data[0]); end
    vectors++; if (beat_data[434] !== 18'h10000) begin miscompares++; $display("FAIL data_centre: got %h required 10000", beat_data[434]); end
    vectors++; if (beat_data[31] !== 18'h01249) begin miscompares++; $display("FAIL data_r1c1: got %h required 01249", beat_data[31]); end
  endtask

  task automatic test_random_stall();
    run_sweep(1, -1, -1);
    vectors++; if (s_timeout !== 0) begin miscompares++; $display("FAIL rand_timeout: got %0d required 0", s_timeout); end
    vectors++; if (s_nbeats !== NB) begin miscompares++; $display("FAIL rand_beats: got %0d required %0d", s_nbeats, NB); end
    vectors++; if (s_order_err !== 0) begin miscompares++; $display("FAIL rand_order: got %0d errors required 0", s_order_err); end
    vectors++; if (s_data_err !== 0) begin miscompares++; $display("FAIL rand_data: got %0d errors required 0", s_data_err); end
    vectors++; if (s_stall_err !== 0) begin miscompares++; $display("FAIL rand_stall_hold: got %0d errors required 0", s_stall_err); end
    vectors++; if (s_ndone !== 1 || s_done_err !== 0) begin miscompares++; $display("FAIL rand_done: got count %0d timing errors %0d required 1 0", s_ndone, s_done_err); end
    vectors++; if (s_busy_err !== 0) begin miscompares++; $display("FAIL rand_busy: got %0d errors required 0", s_busy_err); end
  endtask

  task automatic test_restart_ignored();
    run_sweep(0, 300, -1);
    vectors++; if (s_nbeats !== NB) begin miscompares++; $display("FAIL restart_beats: got %0d required %0d", s_nbeats, NB); end
    vectors++; if (s_order_err !== 0) begin miscompares++; $display("FAIL restart_order: got %0d errors required 0", s_order_err); end
    vectors++; if (s_ndone !== 1) begin miscompares++; $display("FAIL restart_done_count: got %0d required 1", s_ndone); end
    vectors++; if (s_done_cycle !== 902) begin miscompares++; $display("FAIL restart_done_cycle: got %0d required 902", s_done_cycle); end
  endtask

  task automatic test_reset_abort();
    run_sweep(0, -1, 450);
    vectors++; if (s_nbeats !== 450) begin miscompares++; $display("FAIL abort_beats: got %0d required 450", s_nbeats); end
    vectors++; if (s_post_err !== 0) begin miscompares++; $display("FAIL abort_quiet: got %0d errors required 0", s_post_err); end
    vectors++; if (s_ndone !== 0) begin miscompares++; $display("FAIL abort_done: got %0d required 0", s_ndone); end
    run_sweep(0, -1, -1);
    vectors++; if (s_first_valid !== 2) begin miscompares++; $display("FAIL resweep_first_valid: got %0d required 2", s_first_valid); end
    vectors++; if (s_nbeats !== NB || s_order_err !== 0) begin miscompares++; $display("FAIL resweep_beats: got %0d order errors %0d required %0d 0", s_nbeats, s_order_err, NB); end
    vectors++; if (s_ndone !== 1 || s_done_cycle !== 902) begin miscompares++; $display("FAIL resweep_done: got count %0d cycle %0d required 1 902", s_ndone, s_done_cycle); end
  endtask

  task automatic test_final_stall();
    run_sweep(2, -1, -1);
    vectors++; if (s_final_cycle !== 906) begin miscompares++; $display("FAIL final_accept_cycle: got %0d required 906", s_final_cycle); end
    vectors++; if (s_done_cycle !== 907) begin miscompares++; $display("FAIL final_done_cycle: got %0d required 907", s_done_cycle); end
    vectors++; if (s_ndone !== 1 || s_done_err !== 0) begin miscompares++; $display("FAIL final_done_width: got count %0d errors %0d required 1 0", s_ndone, s_done_err); end
    vectors++; if (s_stall_err !== 0) begin miscompares++; $display("FAIL final_stall_hold: got %0d errors required 0", s_stall_err); end
    vectors++; if (s_busy_err !== 0) begin miscompares++; $display("FAIL final_busy: got %0d errors required 0", s_busy_err); end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    wr_ready = 1'b1;
    fill_lut();
    test_reset();
    test_full_sweep();
    test_random_stall();
    test_restart_ignored();
    test_reset_abort();
    test_final_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/drum_init_loader.md
DRUM_INIT_LOADER -- requirements
Module: drum_init_loader

Interface
REQ-001 SHALL have parameter N_ROWS, default 30, grid rows.
REQ-002 SHALL have parameter N_COLS, default 30, grid columns.
REQ-003 SHALL have parameter NODE_W, default 18, node value width.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  single-cycle request to begin a load sweep.
REQ-007 SHALL have port lut_addr  output  19  flattened node address to the init-values LUT.
REQ-008 SHALL have port lut_data  input  NODE_W  combinational LUT value for lut_addr.
REQ-009 SHALL have port wr_valid  output  1  write beat present.
REQ-010 SHALL have port wr_ready  input  1  node memories accept beat.
REQ-011 SHALL have port wr_col  output  5  target column memory index.
REQ-012 SHALL have port wr_row  output  5  target row within column memory.
REQ-013 SHALL have port wr_data  output  NODE_W  value for both u_curr and u_prev memories.
REQ-014 SHALL have port busy  output  1  sweep in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse at sweep completion.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-017 SHALL go IDLE->LOAD on start=1; start in LOAD or DONE SHALL be ignored.
REQ-018 SHALL clear row/col counters to 0 on entering LOAD.
REQ-019 SHALL sweep column-major: row 0..N_ROWS-1 inner, col 0..N_COLS-1 outer.
REQ-020 SHALL drive lut_addr = row*N_COLS + col combinationally from counters; lut_addr = 0 outside LOAD.
REQ-021 SHALL register lut_data, row, col into wr_data, wr_row, wr_col with wr_valid=1 one cycle after the address is presented (1-cycle latency).
REQ-022 SHALL count a beat accepted only when wr_valid && wr_ready in the same cycle.
REQ-023 While wr_valid && !wr_ready, wr_valid/wr_data/wr_row/wr_col SHALL hold unchanged and counters SHALL not advance.
REQ-024 With wr_ready held 1, SHALL issue exactly N_ROWS*N_COLS beats on consecutive cycles, no bubbles.
REQ-025 Counter wrap: row==N_ROWS-1 advance SHALL reset row to 0 and increment col.
REQ-026 After the (N_ROWS-1, N_COLS-1) address is loaded, SHALL stop advancing and issue no further addresses.
REQ-027 On acceptance of the final beat SHALL enter DONE; wr_valid SHALL drop the same edge.
REQ-028 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-029 busy SHALL be 1 in every LOAD cycle, 0 in IDLE and DONE.
REQ-030 wr_data SHALL pass lut_data unmodified (no sign extension, truncation or scaling).

Reset
REQ-031 reset=1 SHALL force state IDLE, counters 0, wr_valid=0, wr_data=0, wr_row=0, wr_col=0, busy=0, done=0 at the next edge.
REQ-032 Reset mid-sweep SHALL abort with no further beats; a following start SHALL restart from (0,0).
REQ-033 reset and start asserted together SHALL resolve as reset.

Structure
REQ-034 Shared package drum_pkg SHALL hold N_ROWS, N_COLS, NODE_W, LUT_ADDR_W=19, IDX_W=5 and the loader state enum.
REQ-035 Row/column counter with wrap and last-node flag SHALL be sub-module drum_grid_counter, reused by the solver sweep.
REQ-036 No memories inside; the LUT and node memories stay external.

Verification
REQ-037 Reset, start at cycle 0, wr_ready=1 -> first wr_valid cycle 2 with row=0,col=0,data=0x00000; 900 beats; done pulse at cycle 902; busy 0 after.
REQ-038 Centre check -> beat (row 14,col 14) drives lut_addr 434 and wr_data 0x10000; beat (row 1,col 1) wr_data 0x01249.
REQ-039 wr_ready toggling 1,0,0,1 pseudo-randomly -> every (row,col) written exactly once, in order, outputs stable during stalls, done only after beat 900.
REQ-040 start pulsed again at beat 300 -> ignored; total still 900 beats and one done pulse.
REQ-041 reset at beat 450 -> wr_valid 0 next cycle, no done; new start -> full 900-beat sweep from (0,0).
REQ-042 wr_ready=0 on final beat for 5 cycles -> done delayed to cycle after acceptance, exactly one cycle wide.
